// File: rtl/elab_slot_sched_pkg.sv
// rtl/elab_slot_sched_pkg.sv - shared parameters, slot/bank types and FSM states
package elab_slot_pkg;

  parameter int NREQ  = 5;
  parameter int DW    = 6;
  parameter int NSLOT = 4;

  localparam int PTRW = $clog2(NREQ);
  localparam int IDXW = $clog2(NSLOT);

  typedef logic [DW-1:0]       slot_t;
  typedef slot_t [NSLOT-1:0]   bank_t;
  typedef logic [PTRW-1:0]     ptr_t;
  typedef logic [IDXW-1:0]     idx_t;

  localparam int BANKW = $bits(bank_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/elab_slot_sched_if.sv
// rtl/elab_slot_sched_if.sv - request/grant and sweep stream bundle
interface elab_slot_sched_if;
  import elab_slot_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  ptr_t                 grant_id;
  logic                 grant_valid;
  logic                 sweep_start;
  logic                 sweep_busy;
  logic                 sweep_valid;
  idx_t                 sweep_idx;
  slot_t                sweep_data;
  logic                 sweep_done;
  logic [BANKW-1:0]     bank_out;

  modport master (
    output req_valid, req_data, req_idx, sweep_start,
    input  req_ready, grant_id, grant_valid, sweep_busy, sweep_valid,
           sweep_idx, sweep_data, sweep_done, bank_out
  );

  modport slave (
    input  req_valid, req_data, req_idx, sweep_start,
    output req_ready, grant_id, grant_valid, sweep_busy, sweep_valid,
           sweep_idx, sweep_data, sweep_done, bank_out
  );

endinterface

// File: rtl/elab_slot_sched_rr_arb.sv
// rtl/elab_slot_sched_rr_arb.sv - combinational round-robin picker over NREQ requesters
module elab_rr_arb
  import elab_slot_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  ptr_t            ptr,
  output logic [NREQ-1:0] grant,
  output ptr_t            winner,
  output logic            any_valid
);

  // Scan from ptr upward, wrapping at NREQ (not at 2^PTRW); first set bit wins.
  always_comb begin
    int   cand;
    ptr_t cidx;
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = ptr_t'(cand);
      if (!any_valid && req[cidx]) begin
        any_valid   = 1'b1;
        winner      = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elab_slot_sched.sv
// rtl/elab_slot_sched.sv - round-robin slot bank writer with sweep readout sequencer
module elab_slot_sched
  import elab_slot_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  elab_slot_sched_if.slave bus
);

  state_t          state;
  state_t          state_nx;
  ptr_t            ptr;
  bank_t           bank;
  idx_t            sweep_pos;
  logic [NREQ-1:0] arb_grant;
  ptr_t            arb_winner;
  logic            arb_any;
  logic            grant_en;
  slot_t           win_data;
  idx_t            win_idx;

  elab_rr_arb u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .winner    (arb_winner),
    .any_valid (arb_any)
  );

  assign win_data = bus.req_data[int'(arb_winner)*DW +: DW];
  assign win_idx  = bus.req_idx[int'(arb_winner)*IDXW +: IDXW];

  // Next state and grant enable; a sweep request in IDLE pre-empts any grant.
  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.sweep_start) state_nx = ST_SWEEP;
        else                 grant_en = arb_any & rst_n;
      end
      ST_SWEEP: begin
        if (sweep_pos == idx_t'(NSLOT-1)) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = grant_en ? arb_grant : '0;
  assign bus.grant_valid = grant_en;
  assign bus.grant_id    = grant_en ? arb_winner : '0;
  assign bus.sweep_busy  = (state != ST_IDLE);
  assign bus.sweep_valid = (state == ST_SWEEP);
  assign bus.sweep_done  = (state == ST_DONE);
  assign bus.sweep_idx   = sweep_pos;
  assign bus.sweep_data  = (state == ST_SWEEP) ? bank[sweep_pos] : '0;
  assign bus.bank_out    = bank;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Round-robin pointer moves just past the winner after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (arb_winner == ptr_t'(NREQ-1)) ? '0 : arb_winner + 1'b1;
    end
  end

  // Bank write; out-of-range slot indices are granted but dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (grant_en && (int'(win_idx) < NSLOT)) begin
      bank[win_idx] <= win_data;
    end
  end

  // Sweep position: cleared on sweep start, stepped through the bank, parked at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_pos <= '0;
    end else if (state == ST_IDLE && bus.sweep_start) begin
      sweep_pos <= '0;
    end else if (state == ST_SWEEP) begin
      sweep_pos <= (sweep_pos == idx_t'(NSLOT-1)) ? '0 : sweep_pos + 1'b1;
    end
  end

endmodule

// File: tb/tb_elab_slot_sched.sv
// tb/tb_elab_slot_sched.sv - randomized and directed bench with behavioural scheduler model
module tb_elab_slot_sched;
  import elab_slot_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elab_slot_sched_if bus();

  elab_slot_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: slot contents, pointer, and position in the sweep
  // (0 idle, 1..NSLOT streaming slot cnt-1, NSLOT+1 done cycle).
  int m_bank[NSLOT];
  int m_ptr;
  int m_cnt;

  logic [NREQ-1:0]  obs_ready;
  int               obs_gid;
  logic             obs_gvalid, obs_svalid, obs_sdone, obs_sbusy;
  int               obs_sidx, obs_sdata;
  logic [BANKW-1:0] obs_bank;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_winner();
    if (m_cnt != 0 || bus.sweep_start) return -1;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (m_ptr + i) % NREQ;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [BANKW-1:0] model_bank();
    logic [BANKW-1:0] b;
    b = '0;
    for (int s = 0; s < NSLOT; s++) b[s*DW +: DW] = DW'(m_bank[s]);
    return b;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NSLOT; s++) m_bank[s] = 0;
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  task automatic set_req(input int r, input int data, input int idx);
    bus.req_valid[r] = 1'b1;
    bus.req_data[r*DW +: DW] = DW'(data);
    bus.req_idx[r*IDXW +: IDXW] = IDXW'(idx);
  endtask

  // One clock cycle: compare every output against the model at negedge, then advance the model.
  task automatic step();
    int w;
    int wi;
    logic sv;
    @(negedge clk);
    w  = model_winner();
    sv = (m_cnt >= 1 && m_cnt <= NSLOT);
    obs_ready  = bus.req_ready;
    obs_gid    = int'(bus.grant_id);
    obs_gvalid = bus.grant_valid;
    obs_svalid = bus.sweep_valid;
    obs_sdone  = bus.sweep_done;
    obs_sbusy  = bus.sweep_busy;
    obs_sidx   = int'(bus.sweep_idx);
    obs_sdata  = int'(bus.sweep_data);
    obs_bank   = bus.bank_out;
    check_eq("req_ready", 64'(bus.req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    check_eq("grant_valid", 64'(bus.grant_valid), 64'(w >= 0));
    check_eq("grant_id", 64'(bus.grant_id), (w >= 0) ? 64'(w) : 64'd0);
    check_eq("sweep_busy", 64'(bus.sweep_busy), 64'(m_cnt != 0));
    check_eq("sweep_valid", 64'(bus.sweep_valid), 64'(sv));
    check_eq("sweep_idx", 64'(bus.sweep_idx), sv ? 64'(m_cnt - 1) : 64'd0);
    check_eq("sweep_data", 64'(bus.sweep_data), sv ? 64'(m_bank[m_cnt - 1]) : 64'd0);
    check_eq("sweep_done", 64'(bus.sweep_done), 64'(m_cnt == NSLOT + 1));
    check_eq("bank_out", 64'(bus.bank_out), 64'(model_bank()));
    if (m_cnt == 0) begin
      if (bus.sweep_start) begin
        m_cnt = 1;
      end else if (w >= 0) begin
        wi = int'(bus.req_idx[w*IDXW +: IDXW]);
        if (wi < NSLOT) m_bank[wi] = int'(bus.req_data[w*DW +: DW]);
        m_ptr = (w + 1) % NREQ;
      end
    end else begin
      m_cnt = (m_cnt == NSLOT + 1) ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check_eq({tag, "_grant_valid"}, 64'(bus.grant_valid), 64'd0);
    check_eq({tag, "_grant_id"}, 64'(bus.grant_id), 64'd0);
    check_eq({tag, "_sweep_busy"}, 64'(bus.sweep_busy), 64'd0);
    check_eq({tag, "_sweep_valid"}, 64'(bus.sweep_valid), 64'd0);
    check_eq({tag, "_sweep_done"}, 64'(bus.sweep_done), 64'd0);
    check_eq({tag, "_sweep_idx"}, 64'(bus.sweep_idx), 64'd0);
    check_eq({tag, "_sweep_data"}, 64'(bus.sweep_data), 64'd0);
    check_eq({tag, "_bank_out"}, 64'(bus.bank_out), 64'd0);
  endtask

  // Asynchronous reset with requests held high to show grants are gated; inputs cleared before release.
  task automatic do_reset();
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    bus.req_valid   = '0;
    bus.sweep_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] sw_data[NSLOT];
    int zero_cycles;
    int slot0_seen;
    int guard;

    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_idx     = '0;
    bus.sweep_start = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single requester 2 writes 0x2A to slot 1.
    set_req(2, 'h2A, 1);
    step();
    check_eq("t1_gid", 64'(obs_gid), 64'd2);
    check_eq("t1_ready", 64'(obs_ready), 64'b00100);
    bus.req_valid = '0;
    step();
    check_eq("t1_bank", 64'(obs_bank), 64'h000A80);

    // All requesters continuously valid from ptr 0: strict rotation with wrap.
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, r + 1, r % NSLOT);
    for (int i = 0; i < 2 * NREQ + 1; i++) begin
      step();
      check_eq("t2_rot_gid", 64'(obs_gid), 64'(i % NREQ));
    end
    bus.req_valid = '0;

    // Preload bank, then sweep it.
    do_reset();
    sw_data[0] = 6'h01; sw_data[1] = 6'h2A; sw_data[2] = 6'h15; sw_data[3] = 6'h3F;
    for (int s = 0; s < NSLOT; s++) begin
      set_req(0, int'(sw_data[s]), s);
      step();
    end
    bus.req_valid = '0;
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      step();
      check_eq("t3_svalid", 64'(obs_svalid), 64'd1);
      check_eq("t3_sidx", 64'(obs_sidx), 64'(s));
      check_eq("t3_sdata", 64'(obs_sdata), 64'(sw_data[s]));
      check_eq("t3_busy", 64'(obs_sbusy), 64'd1);
    end
    step();
    check_eq("t3_done", 64'(obs_sdone), 64'd1);
    check_eq("t3_done_busy", 64'(obs_sbusy), 64'd1);
    step();
    check_eq("t3_idle_busy", 64'(obs_sbusy), 64'd0);

    // Sweep start and a write in the same IDLE cycle: sweep wins, write lands after DONE.
    set_req(0, 'h11, 0);
    bus.sweep_start = 1'b1;
    zero_cycles = 0;
    slot0_seen  = -1;
    guard = 0;
    step();
    bus.sweep_start = 1'b0;
    if (obs_ready == '0) zero_cycles++;
    while (obs_ready == '0 && guard < 20) begin
      step();
      if (obs_svalid && obs_sidx == 0) slot0_seen = obs_sdata;
      if (obs_ready == '0) zero_cycles++;
      guard++;
    end
    check_eq("t4_grant_seen", 64'(obs_ready), 64'b00001);
    check_eq("t4_zero_cycles", 64'(zero_cycles), 64'd6);
    check_eq("t4_swept_old", 64'(slot0_seen), 64'h01);
    bus.req_valid = '0;
    step();
    check_eq("t4_bank_slot0", 64'(obs_bank[5:0]), 64'h11);

    // Reset while the sweep is on slot 2.
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    guard = 0;
    while (m_cnt != 3 && guard < 10) begin
      step();
      guard++;
    end
    check_eq("t5_at_idx2", 64'(bus.sweep_idx), 64'd2);
    do_reset();
    set_req(4, 'h07, 2);
    step();
    check_eq("t5_idle_grant", 64'(obs_gid), 64'd4);
    bus.req_valid = '0;

    // Requesters 1 and 3 with ptr at 2: 3 first, then wrap to 1, then 3 again.
    do_reset();
    set_req(1, 'h05, 0);
    step();
    bus.req_valid = '0;
    set_req(1, 'h06, 1);
    set_req(3, 'h09, 3);
    step();
    check_eq("t6_first", 64'(obs_gid), 64'd3);
    step();
    check_eq("t6_wrap", 64'(obs_gid), 64'd1);
    step();
    check_eq("t6_again", 64'(obs_gid), 64'd3);
    bus.req_valid = '0;

    // Random traffic with occasional sweeps, checked cycle by cycle against the model.
    for (int c = 0; c < 400; c++) begin
      bus.req_valid   = NREQ'($urandom);
      bus.req_data    = (NREQ*DW)'({$urandom, $urandom});
      bus.req_idx     = (NREQ*IDXW)'($urandom);
      bus.sweep_start = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
